// File: rtl/q3_pkg.sv
// Shared types and default sizing for the Q3 serial pattern detector.
package q3_pkg;

  // Detector FSM encoding, visible on the state output pins.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } q3_state_e;

  // Default sizing used by the TinyTapeout wrapper.
  localparam int Q3_W     = 4;
  localparam int Q3_CNT_W = 5;

endpackage

// File: rtl/q3_seq_detector_if.sv
// Control/data bundle between the pin wrapper and the detector core.
interface q3_seq_detector_if #(
  parameter int W     = 4,
  parameter int CNT_W = 5
);
  logic             en;
  logic             bit_valid;
  logic             bit_in;
  logic [W-1:0]     pattern;
  logic             overlap;
  logic             clr_count;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic [1:0]       state;

  // Driver side: supplies the stream and controls, observes results.
  modport master (
    output en, bit_valid, bit_in, pattern, overlap, clr_count,
    input  match, match_count, state
  );

  // Detector side.
  modport slave (
    input  en, bit_valid, bit_in, pattern, overlap, clr_count,
    output match, match_count, state
  );
endinterface

// File: rtl/q3_sat_counter.sv
// Saturating up-counter; clear wins over increment.
module q3_sat_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count increments, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst)                           count <= '0;
    else if (clr)                      count <= '0;
    else if (inc && (count != CNT_MAX)) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/q3_seq_detector.sv
// Serial bit-pattern detector: shifts qualified bits into a W-bit window,
// pulses match when the full window equals the live pattern, and keeps a
// saturating match count.
module q3_seq_detector
  import q3_pkg::*;
#(
  parameter int W     = Q3_W,
  parameter int CNT_W = Q3_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  q3_seq_detector_if.slave  bus
);

  localparam int FILL_W = $clog2(W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(W);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_FILL = FILL;
  localparam logic [1:0] ST_HUNT = HUNT;

  logic [W-1:0]      sr, sr_nxt;
  logic [FILL_W-1:0] fill, fill_inc, fill_nxt;
  logic [1:0]        state_q, state_nxt;
  logic              match_q;
  logic              accept;
  logic              hit;

  assign accept = bus.en && bus.bit_valid;

  // Next window/fill and the match decision for this edge; pattern and
  // overlap are used live, never latched.
  always_comb begin
    sr_nxt   = {sr[W-2:0], bus.bit_in};
    fill_inc = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);
    hit      = accept && (sr_nxt == bus.pattern) && (fill_inc == FILL_MAX);
    fill_nxt = fill;
    if (accept) fill_nxt = (hit && !bus.overlap) ? '0 : fill_inc;
    if (fill_nxt == '0)            state_nxt = ST_IDLE;
    else if (fill_nxt == FILL_MAX) state_nxt = ST_HUNT;
    else                           state_nxt = ST_FILL;
  end

  // Window, fill level, registered state and the one-cycle match pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      fill    <= '0;
      state_q <= ST_IDLE;
      match_q <= 1'b0;
    end else begin
      match_q <= hit;
      if (accept) begin
        sr      <= sr_nxt;
        fill    <= fill_nxt;
        state_q <= state_nxt;
      end
    end
  end

  // Match counter; clear acts regardless of enable.
  q3_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr_count),
    .inc   (hit),
    .count (bus.match_count)
  );

  assign bus.match = match_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_q3_seq_detector.sv
// Directed bench for q3_seq_detector: overlap on/off, gaps and enable,
// saturation/clear, mid-window reset, live pattern change.
module tb_q3_seq_detector;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  q3_seq_detector_if #(.W(4), .CNT_W(5)) bus ();

  q3_seq_detector #(.W(4), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one cycle of stream input, then sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic b);
    bus.bit_valid = v;
    bus.bit_in    = b;
    @(posedge clk);
    #1;
    bus.bit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int m, input int st);
    chk({tag, "_match"}, int'(bus.match), m);
    chk({tag, "_state"}, int'(bus.state), st);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.en = 1'b1; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
    bus.pattern = 4'b1011; bus.overlap = 1'b1; bus.clr_count = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk_out("rst", 0, 0);
    chk("rst_cnt", int'(bus.match_count), 0);
    rst = 1'b0;

    // 1: overlap on, stream 1011011
    cyc(1'b1, 1'b1); chk_out("s1b1", 0, 1);
    cyc(1'b1, 1'b0); chk_out("s1b2", 0, 1);
    cyc(1'b1, 1'b1); chk_out("s1b3", 0, 1);
    cyc(1'b1, 1'b1); chk_out("s1b4", 1, 2);
    chk("s1b4_cnt", int'(bus.match_count), 1);
    cyc(1'b1, 1'b0); chk_out("s1b5", 0, 2);
    cyc(1'b1, 1'b1); chk_out("s1b6", 0, 2);
    cyc(1'b1, 1'b1); chk_out("s1b7", 1, 2);
    cyc(1'b0, 1'b0); chk_out("s1idle", 0, 2);
    chk("s1_cnt", int'(bus.match_count), 2);

    // 2: overlap off, same stream
    do_reset();
    bus.overlap = 1'b0;
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
    chk_out("s2b3", 0, 1);
    cyc(1'b1, 1'b1); chk_out("s2b4", 1, 0);
    cyc(1'b1, 1'b0); chk_out("s2b5", 0, 1);
    cyc(1'b1, 1'b1); chk_out("s2b6", 0, 1);
    cyc(1'b1, 1'b1); chk_out("s2b7", 0, 1);
    chk("s2_cnt", int'(bus.match_count), 1);

    // 3: gaps and an ignored bit while disabled; 1,1,0,[1 dropped],0
    do_reset();
    bus.pattern = 4'b1100; bus.overlap = 1'b1;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0); chk_out("s3b3", 0, 1);
    bus.en = 1'b0;
    cyc(1'b1, 1'b1); chk_out("s3en0", 0, 1);
    bus.en = 1'b1;
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0); chk_out("s3b4", 1, 2);
    cyc(1'b0, 1'b0); chk_out("s3after", 0, 2);
    chk("s3_cnt", int'(bus.match_count), 1);

    // 4: saturation at 31, then clear colliding with a match
    do_reset();
    bus.pattern = 4'b1111; bus.overlap = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1, 1'b1);
      if (i == 10) chk("s4_cnt10", int'(bus.match_count), 7);
      if (i == 34) chk("s4_cnt34", int'(bus.match_count), 31);
    end
    chk("s4_sat", int'(bus.match_count), 31);
    bus.clr_count = 1'b1;
    cyc(1'b1, 1'b1);
    bus.clr_count = 1'b0;
    chk("s4_clr_match", int'(bus.match), 1);
    chk("s4_clr_cnt", int'(bus.match_count), 0);
    cyc(1'b1, 1'b1);
    chk("s4_recount", int'(bus.match_count), 1);
    bus.en = 1'b0; bus.clr_count = 1'b1;
    cyc(1'b1, 1'b1);
    bus.en = 1'b1; bus.clr_count = 1'b0;
    chk("s4_clr_en0", int'(bus.match_count), 0);
    chk("s4_en0_match", int'(bus.match), 0);

    // 5: reset mid-window discards 1,0,1
    do_reset();
    bus.pattern = 4'b1011;
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
    do_reset();
    chk_out("s5rst", 0, 0);
    chk("s5rst_cnt", int'(bus.match_count), 0);
    cyc(1'b1, 1'b1); chk_out("s5b1", 0, 1);
    cyc(1'b1, 1'b1); chk_out("s5b2", 0, 1);
    cyc(1'b1, 1'b0); chk_out("s5b3", 0, 1);
    cyc(1'b1, 1'b1); chk_out("s5b4", 0, 2);
    cyc(1'b1, 1'b1); chk_out("s5b5", 1, 2);
    chk("s5_cnt", int'(bus.match_count), 1);

    // 6: pattern changes on the edge accepting the final bit
    do_reset();
    bus.pattern = 4'b0000;
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
    chk_out("s6b3", 0, 1);
    bus.pattern = 4'b1010;
    cyc(1'b1, 1'b0); chk_out("s6b4", 1, 2);
    chk("s6_cnt", int'(bus.match_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q3_seq_detector.md
# q3_seq_detector

Serial bit-pattern detector that forms the core logic behind the Q3 TinyTapeout top, `tt_um_Q3_project`. The top wrapper maps its pins onto this block:

- `ui_in` supplies the serial bit stream and the controls.
- `uio_in` supplies the target pattern.
- `uo_out` carries the match pulse, the FSM state and the match count.

The block shifts in qualified bits, compares the most recent W bits against a programmable pattern, emits a one-cycle match pulse, and keeps a saturating match count.

## Interface
Parameters:
- `W`, 4: pattern width in bits; minimum 2.
- `CNT_W`, 5: width of the match counter.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset. The wrapper drives it from `~rst_n`.
- `en`  in  1  block enable, from the wrapper's `ena`. When low, all state is held.
- `bit_valid`  in  1  qualifies `bit_in` in the current cycle.
- `bit_in`  in  1  serial data bit.
- `pattern`  in  W  target pattern; bit 0 is the newest bit.
- `overlap`  in  1  1 = overlapping matches allowed; 0 = window discarded after a match.
- `clr_count`  in  1  synchronous clear of `match_count`.
- `match`  out  1  one-cycle pulse per detected match.
- `match_count`  out  CNT_W  saturating number of matches.
- `state`  out  2  FSM state: 0 = IDLE, 1 = FILL, 2 = HUNT.

## Operation
- A bit is accepted when `en && bit_valid` is true at a rising edge.
- On acceptance:
  - `sr <= {sr[W-2:0], bit_in}`.
  - `fill` increments and saturates at W. The fill counter is `$clog2(W+1)` bits wide.
- FSM state is derived from `fill`, and `state` is a registered output:
  - IDLE: `fill == 0`.
  - FILL: `0 < fill < W`.
  - HUNT: `fill == W`.
- Match condition: on an accepting edge where the post-shift window equals the current `pattern` and the post-increment `fill` equals W.
  - The comparison uses the `pattern` and `overlap` values sampled on that same edge.
  - `pattern` may change at any time; there is no latching.
- After a match:
  - `overlap == 1`: `fill` stays at W and the state stays HUNT.
  - `overlap == 0`: `fill` is set to 0 and the state goes to IDLE. W fresh bits are then required before the next match.
- `match_count`:
  - Increments by 1 on each match.
  - Saturates at `2^CNT_W - 1` and never wraps.
  - `clr_count` has priority: a clear and a match in the same cycle leave the count at 0.
  - `clr_count` acts even when `en` is low.
- When `en` is low, no bit is accepted, `match` is 0, and `sr`, `fill` and `state` hold.
- Any cycle with no accepted bit drives `match` to 0.

## Timing
- Reset values: `sr = 0`, `fill = 0`, `state = IDLE (0)`, `match = 0`, `match_count = 0`.
- Reset mid-operation discards any partial window. The first possible match is W accepted bits after `rst` deasserts.
- Latency is 1 cycle:
  - `match` and the `match_count` update are visible in the cycle after the accepting edge.
  - `state` is also updated in that cycle.
- Throughput: one bit per cycle. Back-to-back `bit_valid` is fully supported.
- With `overlap == 1`, consecutive matches on consecutive cycles are possible. `match` then stays high for several cycles, one per match, and the count increments each cycle.
- All outputs are registered, so no combinational path runs from input to output.

## Structure
- Package `q3_pkg` holds:
  - the `q3_state_e` enum (IDLE, FILL, HUNT), 2 bits wide;
  - default constants `Q3_W = 4` and `Q3_CNT_W = 5`.
- Sub-module `q3_sat_counter` provides the saturating counter with clear priority.
  - Ports: `clk`, `rst`, `clr`, `inc`, `count`.
  - Parameter: `CNT_W`.
  - It is instantiated once, for `match_count`.
- The wrapper `tt_um_Q3_project` does pin mapping only and must not duplicate any logic from this block.

## Test plan
1. **Overlap on.** Setup: `pattern = 4'b1011`, `overlap = 1`. Stimulus: stream 1,0,1,1,0,1,1, one bit per cycle. Required: `match` pulses one cycle after bits 4 and 7; final `match_count = 2`; `state` sequence 0 → 1 → 1 → 1 → 2 and then stays 2.
2. **Overlap off.** Stimulus: same stream as scenario 1 with `overlap = 0`. Required: a single match after bit 4; `state` returns to 0 then 1; final `match_count = 1`.
3. **Enable and valid gaps.** Stimulus: `pattern = 4'b1100`; bits 1,1,0,0 with `bit_valid` low for 3 cycles between each bit, plus one cycle of `en` low in which `bit_valid = 1` and `bit_in = 1`. Required: exactly one match, immediately after the last 0; the bit offered while `en` was low is ignored.
4. **Saturation and clear.** Setup: `pattern = 4'b1111`, `overlap = 1`. Stimulus: 40 consecutive 1s. Required: `match_count` stops at 31. Then `clr_count` is asserted in the same cycle as a match edge. Required: `match_count = 0` on the next cycle, and a `match` pulse still appears.
5. **Reset mid-window.** Stimulus: accept 1,0,1; pulse `rst` for 1 cycle; then send 1,1,0,1,1. Required: all outputs read 0 and IDLE in the cycle after reset; exactly one match, after the 5th post-reset bit (window 1011).
6. **Live pattern change.** Stimulus: stream 1010 with `pattern` switching from 4'b0000 to 4'b1010 on the edge that accepts the final 0. Required: `match` asserts one cycle later.
